pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/hazard_prio_arb.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices,
// default source count and the per-source stall/flush tables.
package pipe_ctrl_pkg;

    localparam int unsigned STG_PC     = 0;
    localparam int unsigned STG_PRE_IF = 1;
    localparam int unsigned STG_IF_ID  = 2;
    localparam int unsigned STG_ID_EX  = 3;
    localparam int unsigned STG_EX_MEM = 4;
    localparam int unsigned STG_MEM_WB = 5;

    localparam int unsigned DEF_NSTAGE = 6;
    localparam int unsigned DEF_NSRC   = 9;

    // Packed source 8 down to source 0, one NSTAGE-wide slice each
    localparam logic [DEF_NSRC*DEF_NSTAGE-1:0] DEF_STALL_MASK = {
        6'b000000, 6'b111111, 6'b000001, 6'b000011, 6'b011111,
        6'b000111, 6'b001111, 6'b000011, 6'b000001
    };
    localparam logic [DEF_NSRC*DEF_NSTAGE-1:0] DEF_FLUSH_MASK = {
        6'b000110, 6'b000000, 6'b000010, 6'b000100, 6'b100000,
        6'b001000, 6'b010000, 6'b000100, 6'b000000
    };

    localparam logic [DEF_NSTAGE-1:0] DEF_RESET_FLUSH = 6'b011111;
    localparam logic [DEF_NSTAGE-1:0] DEF_ADV_STALL   = 6'b000111;
    localparam logic [DEF_NSTAGE-1:0] DEF_ADV_FLUSH   = 6'b001000;

endpackage

// File: rtl/hazard_prio_arb.sv
// Fixed-priority arbiter: lowest-index active source wins and selects
// its stall/flush pattern from the mask tables.
module hazard_prio_arb
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned             NSRC       = DEF_NSRC,
    parameter int unsigned             NSTAGE     = DEF_NSTAGE,
    parameter logic [NSRC*NSTAGE-1:0]  STALL_MASK = DEF_STALL_MASK,
    parameter logic [NSRC*NSTAGE-1:0]  FLUSH_MASK = DEF_FLUSH_MASK
) (
    input  logic [NSRC-1:0]   eff,
    output logic [NSRC-1:0]   grant,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush
);

    logic found;

    always_comb begin
        grant = '0;
        stall = '0;
        flush = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (eff[i] && !found) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                stall    = STALL_MASK[i*NSTAGE +: NSTAGE];
                flush    = FLUSH_MASK[i*NSTAGE +: NSTAGE];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates hazard sources into stall/flush
// vectors, holds pulse requests until served, and watches for stuck stalls.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned             NSTAGE      = DEF_NSTAGE,
    parameter int unsigned             NSRC        = DEF_NSRC,
    parameter logic [NSRC*NSTAGE-1:0]  STALL_MASK  = DEF_STALL_MASK,
    parameter logic [NSRC*NSTAGE-1:0]  FLUSH_MASK  = DEF_FLUSH_MASK,
    parameter logic [NSRC-1:0]         PULSE_SRC   = '0,
    parameter int unsigned             ADV_SRC     = 0,
    parameter logic [NSRC-1:0]         ADV_APPLY   = '0,
    parameter logic [NSTAGE-1:0]       ADV_STALL   = DEF_ADV_STALL,
    parameter logic [NSTAGE-1:0]       ADV_FLUSH   = DEF_ADV_FLUSH,
    parameter logic [NSTAGE-1:0]       RESET_FLUSH = DEF_RESET_FLUSH,
    parameter int unsigned             TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC-1:0]   req_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-1:0] flush_o,
    output logic [NSRC-1:0]   grant_o,
    output logic              force_adv_o,
    output logic              timeout_o,
    output logic [31:0]       stall_cycles_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [NSRC-1:0]   pend;
    logic [NSRC-1:0]   pend_next;
    logic [NSRC-1:0]   eff;
    logic [NSRC-1:0]   arb_grant;
    logic [NSTAGE-1:0] arb_stall;
    logic [NSTAGE-1:0] arb_flush;
    logic              adv_prev;
    logic              force_adv;
    logic              stall_any;
    logic [TW-1:0]     wd;
    logic [TW-1:0]     wd_next;

    assign eff = req_i | (pend & PULSE_SRC);

    hazard_prio_arb #(
        .NSRC       (NSRC),
        .NSTAGE     (NSTAGE),
        .STALL_MASK (STALL_MASK),
        .FLUSH_MASK (FLUSH_MASK)
    ) u_arb (
        .eff   (eff),
        .grant (arb_grant),
        .stall (arb_stall),
        .flush (arb_flush)
    );

    // Falling edge of the advance source opens a one-cycle override window
    assign force_adv = adv_prev & ~req_i[ADV_SRC];

    always_comb begin
        grant_o     = '0;
        stall_o     = '0;
        flush_o     = RESET_FLUSH;
        force_adv_o = 1'b0;
        if (rst_n) begin
            grant_o     = arb_grant;
            force_adv_o = force_adv;
            if (force_adv && |(arb_grant & ADV_APPLY)) begin
                stall_o = ADV_STALL;
                flush_o = ADV_FLUSH;
            end else begin
                stall_o = arb_stall;
                flush_o = arb_flush;
            end
        end
    end

    assign stall_any = |stall_o;

    // Pulse sources stay pending until they actually win; repeats merge
    assign pend_next = (pend | req_i) & ~arb_grant & PULSE_SRC;

    always_comb begin
        wd_next = '0;
        if (stall_any) begin
            wd_next = (wd == TW'(TIMEOUT)) ? wd : wd + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend           <= '0;
            adv_prev       <= 1'b0;
            wd             <= '0;
            timeout_o      <= 1'b0;
            stall_cycles_o <= '0;
        end else begin
            pend     <= pend_next;
            adv_prev <= req_i[ADV_SRC];
            wd       <= wd_next;
            if (wd_next == TW'(TIMEOUT)) begin
                timeout_o <= 1'b1;
            end
            if (stall_any) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors push
// expected outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] req_i;
    logic [5:0] stall_o;
    logic [5:0] flush_o;
    logic [8:0] grant_o;
    logic       force_adv_o;
    logic       timeout_o;
    logic [31:0] stall_cycles_o;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .NSTAGE    (6),
        .NSRC      (9),
        .PULSE_SRC (9'h010),
        .ADV_SRC   (1),
        .ADV_APPLY (9'h004),
        .TIMEOUT   (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .grant_o        (grant_o),
        .force_adv_o    (force_adv_o),
        .timeout_o      (timeout_o),
        .stall_cycles_o (stall_cycles_o)
    );

    // Hand-written copy of the default mask table and fixed patterns
    localparam logic [5:0] S0 = 6'b000001, F0 = 6'b000000;
    localparam logic [5:0] S1 = 6'b000011, F1 = 6'b000100;
    localparam logic [5:0] S2 = 6'b001111, F2 = 6'b010000;
    localparam logic [5:0] S3 = 6'b000111, F3 = 6'b001000;
    localparam logic [5:0] S4 = 6'b011111, F4 = 6'b100000;
    localparam logic [5:0] S5 = 6'b000011, F5 = 6'b000100;
    localparam logic [5:0] RF = 6'b011111;
    localparam logic [5:0] AS = 6'b000111, AF = 6'b001000;
    localparam logic [5:0] Z6 = 6'b000000;

    typedef struct {
        string      nm;
        logic [8:0] g;
        logic [5:0] s;
        logic [5:0] f;
        logic       fa;
        logic       to;
        int         cnt;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h, expected %0h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "grant",     32'(grant_o),     32'(e.g));
            chk(e.nm, "stall",     32'(stall_o),     32'(e.s));
            chk(e.nm, "flush",     32'(flush_o),     32'(e.f));
            chk(e.nm, "force_adv", 32'(force_adv_o), 32'(e.fa));
            chk(e.nm, "timeout",   32'(timeout_o),   32'(e.to));
            chk(e.nm, "stall_cyc", stall_cycles_o,   32'(e.cnt));
        end
    end

    task automatic cyc(input string nm, input logic rn, input logic [8:0] r,
                       input logic [8:0] g, input logic [5:0] s, input logic [5:0] f,
                       input logic fa, input logic to, input int cnt);
        exp_t e;
        rst_n = rn;
        req_i = r;
        e.nm = nm; e.g = g; e.s = s; e.f = f; e.fa = fa; e.to = to; e.cnt = cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_i = '0;
        repeat (2) @(posedge clk);
        #1;
        //   name        rst  req     grant   stall flush fa  to  cnt
        cyc("rst_idle",  0, 9'h000, 9'h000, Z6, RF, 0, 0, 0);
        cyc("rst_reqs",  0, 9'h1FF, 9'h000, Z6, RF, 0, 0, 0);
        cyc("post_rst",  1, 9'h000, 9'h000, Z6, Z6, 0, 0, 0);
        cyc("src3",      1, 9'h008, 9'h008, S3, F3, 0, 0, 0);
        cyc("prio0_5a",  1, 9'h021, 9'h001, S0, F0, 0, 0, 1);
        cyc("prio0_5b",  1, 9'h021, 9'h001, S0, F0, 0, 0, 2);
        cyc("drop0",     1, 9'h020, 9'h020, S5, F5, 0, 0, 3);
        cyc("idle1",     1, 9'h000, 9'h000, Z6, Z6, 0, 0, 4);
        cyc("lose5_a",   1, 9'h021, 9'h001, S0, F0, 0, 0, 4);
        cyc("lose5_b",   1, 9'h000, 9'h000, Z6, Z6, 0, 0, 5);
        cyc("pulse4_a",  1, 9'h012, 9'h002, S1, F1, 0, 0, 5);
        cyc("pulse4_b",  1, 9'h002, 9'h002, S1, F1, 0, 0, 6);
        cyc("pulse4_c",  1, 9'h002, 9'h002, S1, F1, 0, 0, 7);
        cyc("pulse4_g",  1, 9'h000, 9'h010, S4, F4, 1, 0, 8);
        cyc("pulse4_d",  1, 9'h000, 9'h000, Z6, Z6, 0, 0, 9);
        cyc("merge_a",   1, 9'h011, 9'h001, S0, F0, 0, 0, 9);
        cyc("merge_b",   1, 9'h011, 9'h001, S0, F0, 0, 0, 10);
        cyc("merge_g",   1, 9'h000, 9'h010, S4, F4, 0, 0, 11);
        cyc("merge_d",   1, 9'h000, 9'h000, Z6, Z6, 0, 0, 12);
        cyc("adv_a",     1, 9'h006, 9'h002, S1, F1, 0, 0, 12);
        cyc("adv_fire",  1, 9'h004, 9'h004, AS, AF, 1, 0, 13);
        cyc("adv_after", 1, 9'h004, 9'h004, S2, F2, 0, 0, 14);
        cyc("idle2",     1, 9'h000, 9'h000, Z6, Z6, 0, 0, 15);
        for (int i = 0; i < 7; i++)
            cyc("wd7", 1, 9'h008, 9'h008, S3, F3, 0, 0, 15 + i);
        cyc("wd7_rel",   1, 9'h000, 9'h000, Z6, Z6, 0, 0, 22);
        for (int i = 0; i < 8; i++)
            cyc("wd8", 1, 9'h008, 9'h008, S3, F3, 0, 0, 22 + i);
        cyc("to_set",    1, 9'h000, 9'h000, Z6, Z6, 0, 1, 30);
        cyc("to_hold",   1, 9'h000, 9'h000, Z6, Z6, 0, 1, 30);
        cyc("pend_set",  1, 9'h011, 9'h001, S0, F0, 0, 1, 30);
        cyc("mid_rst",   0, 9'h000, 9'h000, Z6, RF, 0, 1, 31);
        cyc("no_replay", 1, 9'h000, 9'h000, Z6, Z6, 0, 0, 0);
        cyc("no_replay2",1, 9'h000, 9'h000, Z6, Z6, 0, 0, 0);
        cyc("new_req",   1, 9'h008, 9'h008, S3, F3, 0, 0, 0);
        cyc("final",     1, 9'h000, 9'h000, Z6, Z6, 0, 0, 1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries never checked", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
